// File: rtl/dwrr_pkt_sched_pkg.sv
// ---------------------------------------------------------------------------
// dwrr_sched_pkg
// Shared types and helpers for the packet-granular DWRR scheduler:
//   state_e    - scheduler FSM states
//   calc_dwid  - deficit counter width from quantum and length widths
//   sat_add    - add with a ceiling (covers width saturation and the cap)
// ---------------------------------------------------------------------------
package dwrr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        CHECK  = 2'd2,
        XFER   = 2'd3
    } state_e;

    // One bit wider than the wider of quantum/length, so a full quantum can be
    // banked on top of a residual deficit without wrapping.
    function automatic int calc_dwid(input int qwid, input int lwid);
        return ((qwid > lwid) ? qwid : lwid) + 1;
    endfunction

    // Returns min(a + b, ceil). The 33-bit sum cannot wrap.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] ceil);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, ceil}) ? ceil : sum[31:0];
    endfunction

endpackage

// File: rtl/dwrr_pkt_sched_if.sv
// ---------------------------------------------------------------------------
// dwrr_pkt_sched_if
// Request/grant bundle between the requesters (master) and the scheduler
// (slave).
//   blk            master->slave  downstream stall
//   reqs           master->slave  per-requester packet pending
//   input_quantums master->slave  packed quanta, QWID bits per requester
//   pkt_lens       master->slave  packed head-packet lengths, LWID bits each
//   gnt            slave->master  one-hot beat grant
//   beat_last      slave->master  granted beat is the packet's last
//   busy           slave->master  a packet transfer is in progress
// ---------------------------------------------------------------------------
interface dwrr_pkt_sched_if #(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int LWID     = 8
);
    logic                     blk;
    logic [NUM_REQS-1:0]      reqs;
    logic [NUM_REQS*QWID-1:0] input_quantums;
    logic [NUM_REQS*LWID-1:0] pkt_lens;
    logic [NUM_REQS-1:0]      gnt;
    logic                     beat_last;
    logic                     busy;

    modport master (
        output blk, reqs, input_quantums, pkt_lens,
        input  gnt, beat_last, busy
    );

    modport slave (
        input  blk, reqs, input_quantums, pkt_lens,
        output gnt, beat_last, busy
    );
endinterface

// File: rtl/dwrr_pkt_sched_rr_pridec.sv
// ---------------------------------------------------------------------------
// rr_pridec
// Rotating priority decoder: finds the first set bit of reqs at or after
// index ptr, wrapping at NUM_REQS-1.
//   reqs  in   request vector
//   ptr   in   starting index
//   idx   out  first requesting index (0 when none)
//   any   out  at least one request is set
// ---------------------------------------------------------------------------
module rr_pridec #(
    parameter int NUM_REQS = 4,
    parameter int CNTWID   = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] reqs,
    input  logic [CNTWID-1:0]   ptr,
    output logic [CNTWID-1:0]   idx,
    output logic                any
);
    int j;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that
        // leaves one unassigned would infer a latch.
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            if (reqs[j]) begin
                idx = CNTWID'(j);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dwrr_pkt_sched.sv
// ---------------------------------------------------------------------------
// dwrr_pkt_sched
// Packet-granular deficit-weighted round-robin scheduler. A requester is
// credited its quantum once per visit and may send whole packets while its
// deficit covers the head-packet length; a granted packet is never split.
//   clk  in   clock
//   rst  in   synchronous reset, active-low
//   bus  slave modport of dwrr_pkt_sched_if (reqs, quanta, lengths, blk in;
//        gnt, beat_last, busy out)
// Build option: define DEFICIT_CAP_EN to clamp each credited deficit to DCAP.
// ---------------------------------------------------------------------------
module dwrr_pkt_sched
    import dwrr_sched_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int LWID     = 8,
    parameter int DWID     = calc_dwid(QWID, LWID),
    parameter int CNTWID   = $clog2(NUM_REQS),
    parameter int DCAP     = 2 * (2**QWID - 1)
) (
    input logic             clk,
    input logic             rst,
    dwrr_pkt_sched_if.slave bus
);

`ifdef DEFICIT_CAP_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif
    localparam int SAT_MAX = 2**DWID - 1;
    localparam int CEIL    = (CAP_EN && DCAP < SAT_MAX) ? DCAP : SAT_MAX;

    state_e              state;
    logic [CNTWID-1:0]   ptr;
    logic [LWID-1:0]     beat_cnt;
    logic [DWID-1:0]     deficit [NUM_REQS];

    logic [CNTWID-1:0]   next_idx;
    logic                next_any;
    logic [CNTWID-1:0]   ptr_inc;
    logic [QWID-1:0]     cur_quantum;
    logic [LWID-1:0]     raw_len;
    logic [LWID-1:0]     eff_len;
    logic [DWID-1:0]     eff_len_x;
    logic [DWID-1:0]     cur_def;
    logic [DWID-1:0]     credit_sum;
    logic [DWID-1:0]     def_next;
    logic [NUM_REQS-1:0] def_en;
    logic                beat_fire;

    rr_pridec #(.NUM_REQS(NUM_REQS), .CNTWID(CNTWID)) u_pridec (
        .reqs (bus.reqs),
        .ptr  (ptr),
        .idx  (next_idx),
        .any  (next_any)
    );

    assign ptr_inc     = (ptr == CNTWID'(NUM_REQS - 1)) ? '0 : ptr + CNTWID'(1);
    assign cur_quantum = bus.input_quantums[int'(ptr)*QWID +: QWID];
    assign raw_len     = bus.pkt_lens[int'(ptr)*LWID +: LWID];
    assign eff_len     = (raw_len == '0) ? LWID'(1) : raw_len;
    assign eff_len_x   = DWID'(eff_len);
    assign cur_def     = deficit[ptr];
    assign credit_sum  = DWID'(sat_add(32'(cur_def), 32'(cur_quantum), 32'(CEIL)));

    // The blk mask is combinational so a stall removes the grant in the same
    // cycle; everything else in the outputs is decoded from registered state.
    assign bus.gnt       = (state == XFER) ? ((NUM_REQS'(1) << ptr) & {NUM_REQS{~bus.blk}})
                                           : '0;
    assign beat_fire     = |bus.gnt;
    assign bus.beat_last = beat_fire & (beat_cnt == '0);
    assign bus.busy      = (state == XFER);

    // Only the deficit under ptr is ever rewritten, during CREDIT or CHECK.
    always_comb begin
        def_next = cur_def;
        def_en   = '0;
        for (int i = 0; i < NUM_REQS; i++)
            def_en[i] = (ptr == CNTWID'(i)) && (state == CREDIT || state == CHECK);
        if (state == CREDIT) begin
            def_next = credit_sum;
        end else if (state == CHECK) begin
            if (!bus.reqs[ptr])            def_next = '0;
            else if (cur_def >= eff_len_x) def_next = cur_def - eff_len_x;
        end
    end

    // NOTE: the deficit array is a handful of flops, not a RAM, so it takes a
    // reset; leaving it unreset would let stale credit leak across a reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQS; i++) deficit[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++)
                if (def_en[i]) deficit[i] <= def_next;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is assigned non-blocking so every register sees the
        // pre-edge values of the others, independent of statement order.
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (next_any) begin
                        ptr   <= next_idx;
                        state <= CREDIT;
                    end
                end
                CREDIT: state <= CHECK;
                CHECK: begin
                    if (bus.reqs[ptr] && cur_def >= eff_len_x) begin
                        beat_cnt <= eff_len - LWID'(1);
                        state    <= XFER;
                    end else begin
                        // Dropped request or insufficient credit: move on.
                        ptr   <= ptr_inc;
                        state <= IDLE;
                    end
                end
                XFER: begin
                    if (beat_fire) begin
                        if (beat_cnt == '0) state <= CHECK;
                        else                beat_cnt <= beat_cnt - LWID'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dwrr_pkt_sched.sv
// ---------------------------------------------------------------------------
// tb_dwrr_pkt_sched
// Self-checking bench for dwrr_pkt_sched: a cycle table for single-requester
// packets, reset mid-packet and stall, followed by hand-written sequences for
// drop/skip, zero quantum, zero length, deficit ceiling and weighted share.
// ---------------------------------------------------------------------------
module tb_dwrr_pkt_sched;
    import dwrr_sched_pkg::*;

    logic clk;
    logic rst;
    int   total_cnt;
    int   pass_cnt;

    dwrr_pkt_sched_if #(.NUM_REQS(4), .QWID(8), .LWID(8)) sif ();

    dwrr_pkt_sched #(.NUM_REQS(4), .QWID(8), .LWID(8), .DCAP(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] reqs;
        logic       blk;
        logic [7:0] len0;
        logic [3:0] gnt;
        logic       last;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic b, input logic [7:0] len,
                       input logic [3:0] g, input logic lst, input logic bsy);
        vec_t v;
        v.rst = r; v.reqs = rq; v.blk = b; v.len0 = len;
        v.gnt = g; v.last = lst; v.busy = bsy;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input int i, input logic [7:0] v);
        sif.input_quantums[i*8 +: 8] = v;
    endtask

    task automatic set_len(input int i, input logic [7:0] v);
        sif.pkt_lens[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sif.reqs = '0;
        sif.blk = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    int beats;
    int b0;
    int b1;
    int bad;
    int diff;

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst = 1'b0;
        sif.blk = 1'b0;
        sif.reqs = '0;
        sif.input_quantums = '0;
        sif.pkt_lens = '0;
        tick();
        tick();
        rst = 1'b1;

        // ---- table: single requester (q0=8, len 4), reset mid-XFER, stall (len 6)
        for (int i = 0; i < 3; i++) add(1, 4'b0001, 0, 4, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 4'b0001, 0, 4, 4'b0001, 0, 1);
        add(1, 4'b0001, 0, 4, 4'b0001, 1, 1);
        add(1, 4'b0001, 0, 4, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 4'b0001, 0, 4, 4'b0001, 0, 1);
        add(1, 4'b0001, 0, 4, 4'b0001, 1, 1);
        add(1, 4'b0001, 0, 4, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 4, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 4'b0001, 0, 4, 4'b0000, 0, 0);
        add(0, 4'b0001, 0, 4, 4'b0001, 0, 1);
        add(0, 4'b1111, 0, 4, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 4, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 4, 4'b0000, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 4'b0011, 0, 6, 4'b0000, 0, 0);
        for (int i = 0; i < 2; i++) add(1, 4'b0011, 0, 6, 4'b0001, 0, 1);
        for (int i = 0; i < 5; i++) add(1, 4'b0011, 1, 6, 4'b0000, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 4'b0011, 0, 6, 4'b0001, 0, 1);
        add(1, 4'b0011, 0, 6, 4'b0001, 1, 1);
        add(1, 4'b0000, 0, 6, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 6, 4'b0000, 0, 0);

        set_q(0, 8);
        beats = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            sif.reqs = vecs[i].reqs;
            sif.blk = vecs[i].blk;
            set_len(0, vecs[i].len0);
            @(negedge clk);
            check($sformatf("row%0d gnt", i), 32'(sif.gnt), 32'(vecs[i].gnt));
            check($sformatf("row%0d beat_last", i), 32'(sif.beat_last), 32'(vecs[i].last));
            check($sformatf("row%0d busy", i), 32'(sif.busy), 32'(vecs[i].busy));
            if (i >= 21 && sif.gnt != 4'b0000) beats++;
            tick();
        end
        check("stall beats", 32'(beats), 32'd6);
        check("stall drop deficit0", 32'(dut.deficit[0]), 32'd0);
        check("stall drop ptr", 32'(dut.ptr), 32'd1);

        // ---- drop and skip: req2 banks 5, then deasserts during its visit
        do_reset();
        set_q(2, 5);
        set_len(2, 10);
        sif.reqs = 4'b0100;
        tick(); tick(); tick();
        sif.reqs = 4'b0000;
        @(negedge clk);
        check("skip deficit2 retained", 32'(dut.deficit[2]), 32'd5);
        check("skip ptr advanced", 32'(dut.ptr), 32'd3);
        tick();
        sif.reqs = 4'b0100;
        tick();
        sif.reqs = 4'b0000;
        tick();
        tick();
        @(negedge clk);
        check("drop deficit2 cleared", 32'(dut.deficit[2]), 32'd0);
        check("drop ptr advanced", 32'(dut.ptr), 32'd3);
        tick();

        // ---- quantum 0: req3 is visited but never granted
        do_reset();
        set_q(3, 0);
        set_len(3, 1);
        sif.reqs = 4'b1000;
        beats = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sif.gnt != 4'b0000) beats++;
            if (sif.busy) bad++;
            tick();
        end
        check("q0 grants", 32'(beats), 32'd0);
        check("q0 busy cycles", 32'(bad), 32'd0);
        check("q0 deficit3", 32'(dut.deficit[3]), 32'd0);
        sif.reqs = 4'b0000;

        // ---- length 0 is a single beat
        do_reset();
        set_q(0, 1);
        set_len(0, 0);
        sif.reqs = 4'b0001;
        tick(); tick(); tick();
        @(negedge clk);
        check("len0 gnt", 32'(sif.gnt), 32'b0001);
        check("len0 beat_last", 32'(sif.beat_last), 32'd1);
        tick();
        sif.reqs = 4'b0000;
        @(negedge clk);
        check("len0 single beat", 32'(sif.gnt), 32'd0);
        tick();

        // ---- deficit ceiling: three visits of quantum 15 against a 255-beat packet
        do_reset();
        set_q(0, 15);
        set_len(0, 255);
        sif.reqs = 4'b0001;
        for (int i = 0; i < 9; i++) tick();
        sif.reqs = 4'b0000;
        @(negedge clk);
`ifdef DEFICIT_CAP_EN
        check("capped deficit0", 32'(dut.deficit[0]), 32'd20);
`else
        check("uncapped deficit0", 32'(dut.deficit[0]), 32'd45);
`endif
        tick();

        // ---- weighted share: quanta 16:8, both len 8, 600 cycles
        do_reset();
        set_q(0, 16);
        set_q(1, 8);
        set_len(0, 8);
        set_len(1, 8);
        sif.reqs = 4'b0011;
        b0 = 0;
        b1 = 0;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sif.gnt[0]) b0++;
            if (sif.gnt[1]) b1++;
            if ($countones(sif.gnt) > 1) bad++;
            tick();
        end
        diff = b0 - 2 * b1;
        if (diff < 0) diff = -diff;
        check("share onehot", 32'(bad), 32'd0);
        check("share ratio within a packet", 32'(diff <= 8), 32'd1);
        check("share req1 beats", 32'(b1 >= 130 && b1 <= 150), 32'd1);

        // ---- reset and hold with all requests pending
        rst = 1'b0;
        sif.reqs = 4'b1111;
        tick();
        tick();
        @(negedge clk);
        check("reset gnt", 32'(sif.gnt), 32'd0);
        check("reset busy", 32'(sif.busy), 32'd0);
        check("reset beat_last", 32'(sif.beat_last), 32'd0);
        check("reset ptr", 32'(dut.ptr), 32'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("reset deficit%0d", i), 32'(dut.deficit[i]), 32'd0);
        tick();
        rst = 1'b1;
        sif.reqs = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
